// File: rtl/ddr_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr_wr_arbiter_if
// Description : DDR write-port bundle shared between the write arbiter and
//               the HPS/DDR bridge. One 32-bit address/data word is offered
//               with a request that stays high until the bridge answers with
//               DDR_WRITE_READY.
// Ports       : DDR_WRITE_ADDR  [31:0] word address toward DDR
//               DDR_WRITE_DATA  [31:0] word data toward DDR
//               DDR_WRITE_REQ          write request, held until READY
//               DDR_WRITE_READY        bridge accepted the current word
// Modports    : master - arbiter side (drives ADDR/DATA/REQ)
//               slave  - bridge side  (drives READY)
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr_wr_arbiter_if;

    logic [31:0] DDR_WRITE_ADDR;
    logic [31:0] DDR_WRITE_DATA;
    logic        DDR_WRITE_REQ;
    logic        DDR_WRITE_READY;

    modport master (
        output DDR_WRITE_ADDR,
        output DDR_WRITE_DATA,
        output DDR_WRITE_REQ,
        input  DDR_WRITE_READY
    );

    modport slave (
        input  DDR_WRITE_ADDR,
        input  DDR_WRITE_DATA,
        input  DDR_WRITE_REQ,
        output DDR_WRITE_READY
    );

endinterface
`default_nettype wire

// File: rtl/ddr_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ddr_wr_arbiter
// Description : Shares the single DDR write port between up to four word
//               writers (detection results, frame markers, debug/stats).
//               One requester is granted at a time; its word is registered
//               onto the DDR port and held until DDR_WRITE_READY, then the
//               requester gets a one-cycle ack. A watchdog aborts a word the
//               DDR side never accepts and pulses err instead. A one-cycle
//               GAP after every transfer lets the requester drop or replace
//               its request before the next arbitration.
// Parameters  : NUM_REQ        number of requesters (1..4)
//               PRIORITY_MODE  0 = round-robin, 1 = fixed (index 0 highest)
//               TIMEOUT_CYCLES cycles to wait for READY before abort
// Ports       : sys_clk    clock, rising edge
//               sys_rst_n  asynchronous active-low reset
//               req_i      per-requester level request
//               addr_i     requester k address at [32k+31:32k]
//               data_i     requester k data at [32k+31:32k]
//               ack_o      one-cycle pulse, word written
//               err_o      one-cycle pulse, word aborted on timeout
//               ddr        DDR write port (master side)
//               grant_id   index of current/last granted requester
//               busy       high whenever the arbiter is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_wr_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [32*NUM_REQ-1:0]  addr_i,
    input  logic [32*NUM_REQ-1:0]  data_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [NUM_REQ-1:0]     err_o,
    ddr_wr_arbiter_if.master       ddr,
    output logic [1:0]             grant_id,
    output logic                   busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_XFER   = 2'd1;
    localparam logic [1:0]  c_ST_GAP    = 2'd2;

    localparam logic [15:0] c_WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] c_WDOG_MAX  = 16'hFFFF;
    // Starting from the highest index makes requester 0 the first
    // round-robin winner after reset.
    localparam logic [1:0]  c_GRANT_RST = 2'(NUM_REQ - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [15:0]         r_wdog;
    logic [31:0]         r_addr;
    logic [31:0]         r_data;
    logic                r_req;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  r_err;
    logic [1:0]          r_grant;

    // ------------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------------
    logic                w_any;
    logic [1:0]          w_winner;
    logic [31:0]         w_win_addr;
    logic [31:0]         w_win_data;
    logic [NUM_REQ-1:0]  w_grant_onehot;
    int                  w_best;
    int                  w_dist;

    // Each requesting index gets a distance: its own index in fixed-priority
    // mode, or its position in the scan that starts just after the last grant
    // in round-robin mode. The smallest distance wins. Since r_grant never
    // exceeds NUM_REQ-1 the round-robin distance expression stays
    // non-negative before the modulo.
    always_comb begin
        w_any      = |req_i;
        w_winner   = r_grant;
        w_win_addr = 32'd0;
        w_win_data = 32'd0;
        w_best     = NUM_REQ;
        w_dist     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (PRIORITY_MODE == 1) begin
                w_dist = k;
            end else begin
                w_dist = (k + NUM_REQ - 1 - int'(r_grant)) % NUM_REQ;
            end
            if (req_i[k] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_winner   = 2'(k);
                w_win_addr = addr_i[32*k +: 32];
                w_win_data = data_i[32*k +: 32];
            end
        end
    end

    assign w_grant_onehot = NUM_REQ'(1) << r_grant;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_ST_IDLE;
            r_wdog  <= 16'd0;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
            r_req   <= 1'b0;
            r_ack   <= '0;
            r_err   <= '0;
            r_grant <= c_GRANT_RST;
        end else begin
            // ack/err are single-cycle pulses by default
            r_ack <= '0;
            r_err <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_addr  <= w_win_addr;
                        r_data  <= w_win_data;
                        r_req   <= 1'b1;
                        r_grant <= w_winner;
                        r_wdog  <= 16'd0;
                        r_state <= c_ST_XFER;
                    end
                end
                c_ST_XFER: begin
                    // READY takes precedence over a timeout on the same edge.
                    // Dropping req_i here does not cancel the word.
                    if (ddr.DDR_WRITE_READY) begin
                        r_req   <= 1'b0;
                        r_ack   <= w_grant_onehot;
                        r_state <= c_ST_GAP;
                    end else if (r_wdog == c_WDOG_LAST) begin
                        r_req   <= 1'b0;
                        r_err   <= w_grant_onehot;
                        r_state <= c_ST_GAP;
                    end else if (r_wdog != c_WDOG_MAX) begin
                        r_wdog  <= r_wdog + 16'd1;
                    end
                end
                c_ST_GAP: begin
                    // No grant here: the requester uses this cycle to react
                    // to its ack/err pulse.
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ddr.DDR_WRITE_ADDR = r_addr;
    assign ddr.DDR_WRITE_DATA = r_data;
    assign ddr.DDR_WRITE_REQ  = r_req;
    assign ack_o              = r_ack;
    assign err_o              = r_err;
    assign grant_id           = r_grant;
    assign busy               = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ddr_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_wr_arbiter
// Description : Self-checking bench for ddr_wr_arbiter. Two instances share
//               the stimulus variables: a round-robin one and a fixed-
//               priority one, both with a short watchdog. sel chooses which
//               instance receives requests/READY and which one is observed;
//               the other sees no requests. Directed scenarios are followed
//               by randomized traffic checked cycle by cycle against a
//               timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_wr_arbiter;

    localparam int N = 3;
    localparam int T = 8;

    logic            sys_clk   = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic            sel       = 1'b0;
    logic [N-1:0]    req       = '0;
    logic [32*N-1:0] addr      = '0;
    logic [32*N-1:0] data      = '0;
    logic            ready     = 1'b0;
    int              total     = 0;
    int              bad       = 0;

    always #5 sys_clk = ~sys_clk;

    ddr_wr_arbiter_if bus_rr ();
    ddr_wr_arbiter_if bus_fp ();

    logic [N-1:0] w_ack_rr, w_err_rr, w_ack_fp, w_err_fp;
    logic [1:0]   w_gid_rr, w_gid_fp;
    logic         w_busy_rr, w_busy_fp;
    logic [N-1:0] w_req_rr, w_req_fp;

    assign w_req_rr = sel ? '0 : req;
    assign w_req_fp = sel ? req : '0;
    assign bus_rr.DDR_WRITE_READY = ready & ~sel;
    assign bus_fp.DDR_WRITE_READY = ready & sel;

    ddr_wr_arbiter #(.NUM_REQ(N), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(T)) u_rr (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_i     (w_req_rr),
        .addr_i    (addr),
        .data_i    (data),
        .ack_o     (w_ack_rr),
        .err_o     (w_err_rr),
        .ddr       (bus_rr),
        .grant_id  (w_gid_rr),
        .busy      (w_busy_rr)
    );

    ddr_wr_arbiter #(.NUM_REQ(N), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(T)) u_fp (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_i     (w_req_fp),
        .addr_i    (addr),
        .data_i    (data),
        .ack_o     (w_ack_fp),
        .err_o     (w_err_fp),
        .ddr       (bus_fp),
        .grant_id  (w_gid_fp),
        .busy      (w_busy_fp)
    );

    // Observed view of the selected instance
    logic         w_oreq, w_obusy;
    logic [31:0]  w_oaddr, w_odata;
    logic [N-1:0] w_oack, w_oerr;
    logic [1:0]   w_ogid;

    assign w_oreq  = sel ? bus_fp.DDR_WRITE_REQ  : bus_rr.DDR_WRITE_REQ;
    assign w_oaddr = sel ? bus_fp.DDR_WRITE_ADDR : bus_rr.DDR_WRITE_ADDR;
    assign w_odata = sel ? bus_fp.DDR_WRITE_DATA : bus_rr.DDR_WRITE_DATA;
    assign w_oack  = sel ? w_ack_fp  : w_ack_rr;
    assign w_oerr  = sel ? w_err_fp  : w_err_rr;
    assign w_ogid  = sel ? w_gid_fp  : w_gid_rr;
    assign w_obusy = sel ? w_busy_fp : w_busy_rr;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req       = '0;
        ready     = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        sys_rst_n = 1'b0;
        req       = '0;
        ready     = 1'b0;
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            total++; if (w_oreq !== 1'b0) begin bad++; $display("FAIL rst_req inst=%0d got=%b want=0", s, w_oreq); end
            total++; if (w_oaddr !== 32'd0) begin bad++; $display("FAIL rst_addr inst=%0d got=%h want=0", s, w_oaddr); end
            total++; if (w_odata !== 32'd0) begin bad++; $display("FAIL rst_data inst=%0d got=%h want=0", s, w_odata); end
            total++; if (w_oack !== 3'b000 || w_oerr !== 3'b000) begin bad++; $display("FAIL rst_pulses inst=%0d ack=%b err=%b want=000", s, w_oack, w_oerr); end
            total++; if (w_ogid !== 2'd2) begin bad++; $display("FAIL rst_gid inst=%0d got=%0d want=2", s, w_ogid); end
            total++; if (w_obusy !== 1'b0) begin bad++; $display("FAIL rst_busy inst=%0d got=%b want=0", s, w_obusy); end
        end
        sel       = 1'b0;
        sys_rst_n = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single();
        sel = 1'b0;
        do_reset();
        addr[31:0] = 32'h0900_0001;
        data[31:0] = 32'hC012_3456;
        req        = 3'b001;
        tick();
        total++; if (w_oreq !== 1'b1) begin bad++; $display("FAIL sw_req got=%b want=1", w_oreq); end
        total++; if (w_oaddr !== 32'h0900_0001) begin bad++; $display("FAIL sw_addr got=%h want=09000001", w_oaddr); end
        total++; if (w_odata !== 32'hC012_3456) begin bad++; $display("FAIL sw_data got=%h want=c0123456", w_odata); end
        total++; if (w_ogid !== 2'd0) begin bad++; $display("FAIL sw_gid got=%0d want=0", w_ogid); end
        total++; if (w_obusy !== 1'b1) begin bad++; $display("FAIL sw_busy got=%b want=1", w_obusy); end
        tick();
        total++; if (w_oreq !== 1'b1 || w_oack !== 3'b000) begin bad++; $display("FAIL sw_hold2 req=%b ack=%b want req=1 ack=000", w_oreq, w_oack); end
        tick();
        total++; if (w_oreq !== 1'b1 || w_oack !== 3'b000) begin bad++; $display("FAIL sw_hold3 req=%b ack=%b want req=1 ack=000", w_oreq, w_oack); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        req   = 3'b000;
        total++; if (w_oreq !== 1'b0) begin bad++; $display("FAIL sw_req_drop got=%b want=0", w_oreq); end
        total++; if (w_oack !== 3'b001 || w_oerr !== 3'b000) begin bad++; $display("FAIL sw_ack ack=%b err=%b want ack=001 err=000", w_oack, w_oerr); end
        tick();
        total++; if (w_oack !== 3'b000 || w_obusy !== 1'b0) begin bad++; $display("FAIL sw_after ack=%b busy=%b want 000/0", w_oack, w_obusy); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_round_robin();
        logic [N-1:0] exp_ack;
        sel = 1'b0;
        do_reset();
        for (int k = 0; k < N; k++) begin
            addr[32*k +: 32] = 32'h1000_0000 + 32'(k);
            data[32*k +: 32] = 32'hD000_0000 + 32'(k);
        end
        req   = 3'b111;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int k;
            k = i % N;
            exp_ack    = '0;
            exp_ack[k] = 1'b1;
            tick();
            total++; if (w_oreq !== 1'b1 || w_ogid !== 2'(k)) begin bad++; $display("FAIL rr_grant i=%0d req=%b gid=%0d want req=1 gid=%0d", i, w_oreq, w_ogid, k); end
            total++; if (w_oaddr !== 32'h1000_0000 + 32'(k) || w_odata !== 32'hD000_0000 + 32'(k)) begin bad++; $display("FAIL rr_word i=%0d addr=%h data=%h want req %0d word", i, w_oaddr, w_odata, k); end
            tick();
            total++; if (w_oreq !== 1'b0 || w_oack !== exp_ack) begin bad++; $display("FAIL rr_ack i=%0d req=%b ack=%b want req=0 ack=%b", i, w_oreq, w_oack, exp_ack); end
            tick();
            total++; if (w_oreq !== 1'b0 || w_oack !== 3'b000 || w_obusy !== 1'b0) begin bad++; $display("FAIL rr_gap i=%0d req=%b ack=%b busy=%b want 0/000/0", i, w_oreq, w_oack, w_obusy); end
        end
        req = '0;
        tick();
        ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_fixed_priority();
        sel = 1'b1;
        do_reset();
        for (int k = 0; k < N; k++) begin
            addr[32*k +: 32] = 32'h2000_0000 + 32'(k);
            data[32*k +: 32] = 32'hE000_0000 + 32'(k);
        end
        req   = 3'b110;
        ready = 1'b0;
        tick();
        total++; if (w_oreq !== 1'b1 || w_ogid !== 2'd1) begin bad++; $display("FAIL fp_first req=%b gid=%0d want 1/1", w_oreq, w_ogid); end
        req = 3'b111;
        tick();
        ready = 1'b1;
        tick();
        total++; if (w_oack !== 3'b010) begin bad++; $display("FAIL fp_ack1 got=%b want=010", w_oack); end
        req = 3'b101;
        tick();
        tick();
        total++; if (w_oreq !== 1'b1 || w_ogid !== 2'd0 || w_oaddr !== 32'h2000_0000) begin bad++; $display("FAIL fp_second req=%b gid=%0d addr=%h want 1/0/20000000", w_oreq, w_ogid, w_oaddr); end
        tick();
        total++; if (w_oack !== 3'b001) begin bad++; $display("FAIL fp_ack0 got=%b want=001", w_oack); end
        req = 3'b100;
        tick();
        tick();
        total++; if (w_oreq !== 1'b1 || w_ogid !== 2'd2) begin bad++; $display("FAIL fp_third req=%b gid=%0d want 1/2", w_oreq, w_ogid); end
        tick();
        total++; if (w_oack !== 3'b100) begin bad++; $display("FAIL fp_ack2 got=%b want=100", w_oack); end
        req = '0;
        tick();
        ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_timeout();
        int n;
        sel = 1'b0;
        do_reset();
        addr[64 +: 32] = 32'h3000_0002;
        data[64 +: 32] = 32'h5555_AAAA;
        req   = 3'b100;
        ready = 1'b0;
        tick();
        n = 0;
        while (w_oreq === 1'b1 && n < 20) begin
            total++; if (w_oack !== 3'b000 || w_oerr !== 3'b000) begin bad++; $display("FAIL to_early_pulse n=%0d ack=%b err=%b want 000", n, w_oack, w_oerr); end
            n++;
            tick();
        end
        total++; if (n !== T) begin bad++; $display("FAIL to_req_cycles got=%0d want=%0d", n, T); end
        total++; if (w_oerr !== 3'b100 || w_oack !== 3'b000) begin bad++; $display("FAIL to_err err=%b ack=%b want err=100 ack=000", w_oerr, w_oack); end
        req = '0;
        tick();
        total++; if (w_oerr !== 3'b000) begin bad++; $display("FAIL to_err_once got=%b want=000", w_oerr); end
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        total++; if (w_oack !== 3'b000 || w_oerr !== 3'b000 || w_oreq !== 1'b0 || w_obusy !== 1'b0) begin bad++; $display("FAIL to_idle_ready ack=%b err=%b req=%b busy=%b want all 0", w_oack, w_oerr, w_oreq, w_obusy); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_coincident();
        sel = 1'b0;
        do_reset();
        addr[31:0] = 32'h4000_0000;
        data[31:0] = 32'h1234_5678;
        req   = 3'b001;
        ready = 1'b0;
        tick();
        repeat (T - 1) tick();
        total++; if (w_oreq !== 1'b1) begin bad++; $display("FAIL co_still_req got=%b want=1", w_oreq); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        req   = '0;
        total++; if (w_oack !== 3'b001 || w_oerr !== 3'b000) begin bad++; $display("FAIL co_ready_wins ack=%b err=%b want ack=001 err=000", w_oack, w_oerr); end
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_async_reset();
        sel = 1'b0;
        do_reset();
        addr[32 +: 32] = 32'h5000_0001;
        req   = 3'b010;
        ready = 1'b0;
        tick();
        tick();
        total++; if (w_oreq !== 1'b1 || w_obusy !== 1'b1) begin bad++; $display("FAIL ar_pre req=%b busy=%b want 1/1", w_oreq, w_obusy); end
        #3 sys_rst_n = 1'b0;
        #1;
        total++; if (w_oreq !== 1'b0 || w_obusy !== 1'b0) begin bad++; $display("FAIL ar_async req=%b busy=%b want 0/0", w_oreq, w_obusy); end
        total++; if (w_oack !== 3'b000 || w_oerr !== 3'b000 || w_ogid !== 2'd2) begin bad++; $display("FAIL ar_async_misc ack=%b err=%b gid=%0d want 000/000/2", w_oack, w_oerr, w_ogid); end
        req = 3'b111;
        tick();
        sys_rst_n = 1'b1;
        tick();
        total++; if (w_oreq !== 1'b1 || w_ogid !== 2'd0) begin bad++; $display("FAIL ar_first_grant req=%b gid=%0d want 1/0", w_oreq, w_ogid); end
        req   = '0;
        ready = 1'b1;
        repeat (4) tick();
        ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Randomized traffic. The reference model follows the transfer timeline:
    // a grant is possible on an edge if the arbiter was idle in the previous
    // cycle; the word stays on the port until an edge with READY (ack) or the
    // T-th edge without READY (err); the pulse cycle is followed by one idle
    // cycle before the next grant edge.
    task automatic test_random(input bit fixed, input int ncyc);
        int           last, nwait, wid, idle_from, pick;
        bit           act;
        logic [N-1:0] r_app, eack, eerr;
        logic [32*N-1:0] a_app, d_app;
        logic         rdy_app, ebusy;
        logic [31:0]  ea, ed;
        sel = fixed;
        do_reset();
        last = N - 1; nwait = 0; wid = 0; idle_from = 0; act = 1'b0;
        ea = 32'd0; ed = 32'd0;
        for (int t = 1; t <= ncyc; t++) begin
            r_app   = req;
            a_app   = addr;
            d_app   = data;
            rdy_app = ready;
            tick();
            eack = '0;
            eerr = '0;
            if (act) begin
                if (rdy_app) begin
                    eack[wid] = 1'b1; act = 1'b0; idle_from = t + 1;
                end else begin
                    nwait++;
                    if (nwait == T) begin
                        eerr[wid] = 1'b1; act = 1'b0; idle_from = t + 1;
                    end
                end
            end else if (t - 1 >= idle_from && r_app != '0) begin
                pick = -1;
                for (int j = 0; j < N; j++) begin
                    int c;
                    c = fixed ? j : (last + 1 + j) % N;
                    if (pick < 0 && r_app[c]) pick = c;
                end
                wid = pick; last = pick; act = 1'b1; nwait = 0;
                ea = a_app[32*pick +: 32];
                ed = d_app[32*pick +: 32];
            end
            ebusy = act || ((eack | eerr) != '0);

            total++; if (w_oreq !== act) begin bad++; $display("FAIL rnd_req mode=%0d cyc=%0d got=%b want=%b", fixed, t, w_oreq, act); end
            total++; if (w_oack !== eack) begin bad++; $display("FAIL rnd_ack mode=%0d cyc=%0d got=%b want=%b", fixed, t, w_oack, eack); end
            total++; if (w_oerr !== eerr) begin bad++; $display("FAIL rnd_err mode=%0d cyc=%0d got=%b want=%b", fixed, t, w_oerr, eerr); end
            total++; if (w_ogid !== 2'(last)) begin bad++; $display("FAIL rnd_gid mode=%0d cyc=%0d got=%0d want=%0d", fixed, t, w_ogid, last); end
            total++; if (w_oaddr !== ea) begin bad++; $display("FAIL rnd_addr mode=%0d cyc=%0d got=%h want=%h", fixed, t, w_oaddr, ea); end
            total++; if (w_odata !== ed) begin bad++; $display("FAIL rnd_data mode=%0d cyc=%0d got=%h want=%h", fixed, t, w_odata, ed); end
            total++; if (w_obusy !== ebusy) begin bad++; $display("FAIL rnd_busy mode=%0d cyc=%0d got=%b want=%b", fixed, t, w_obusy, ebusy); end

            // Requester behaviour: hold until own pulse, then drop or present
            // the next word; idle requesters raise at random; the granted one
            // occasionally drops mid-transfer.
            for (int k = 0; k < N; k++) begin
                if (eack[k] || eerr[k]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        req[k]           = 1'b1;
                        addr[32*k +: 32] = $urandom;
                        data[32*k +: 32] = $urandom;
                    end else begin
                        req[k] = 1'b0;
                    end
                end else if (!req[k] && !(act && wid == k)) begin
                    if ($urandom_range(3, 0) == 0) begin
                        req[k]           = 1'b1;
                        addr[32*k +: 32] = $urandom;
                        data[32*k +: 32] = $urandom;
                    end
                end else if (req[k] && act && wid == k) begin
                    if ($urandom_range(15, 0) == 0) req[k] = 1'b0;
                end
            end
            ready = ($urandom_range(2, 0) == 0);
        end
        req   = '0;
        ready = 1'b1;
        repeat (12) tick();
        ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_priority();
        test_timeout();
        test_coincident();
        test_async_reset();
        test_random(1'b0, 600);
        test_random(1'b1, 600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout sim time exceeded, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ddr_wr_arbiter.md
Name: ddr_wr_arbiter

Overview:
Shares the single DDR write port (DDR_WRITE_ADDR/DATA/REQ/READY) between up to four word-writers: the pedestrian-detection result writer, frame-marker writer, debug/statistics writers. Each requester presents one 32-bit address/data word with a level request. The arbiter grants one requester at a time, registers its word onto the DDR port, holds it until DDR_WRITE_READY, and then acknowledges. A watchdog aborts transfers that the DDR side never accepts. It sits between the per-scale detection result logic and the HPS/DDR bridge, in the sys_clk domain.

Parameters:
NUM_REQ, 3, number of requesters, 1..4
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (index 0 highest)
TIMEOUT_CYCLES, 1023, cycles to wait for DDR_WRITE_READY before abort, 1..65535

Ports:
sys_clk  in  1  clock, all logic on rising edge
sys_rst_n  in  1  reset; asynchronous, active-low
req_i  in  NUM_REQ  per-requester level request; addr/data stable while high
addr_i  in  32*NUM_REQ  requester k address at [32k+31:32k]
data_i  in  32*NUM_REQ  requester k data at [32k+31:32k]
ack_o  out  NUM_REQ  one-cycle pulse: word written
err_o  out  NUM_REQ  one-cycle pulse: word aborted on timeout
DDR_WRITE_ADDR  out  32  registered address to DDR
DDR_WRITE_DATA  out  32  registered data to DDR
DDR_WRITE_REQ  out  1  write request, held until READY
DDR_WRITE_READY  in  1  DDR accepted current word
grant_id  out  2  index of current/last granted requester
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release by sys_rst_n going high): state IDLE; ack_o=0, err_o=0, DDR_WRITE_REQ=0, DDR_WRITE_ADDR=0, DDR_WRITE_DATA=0, grant_id=NUM_REQ-1 (so index 0 wins first RR round), busy=0, watchdog=0.
- FSM states: IDLE, XFER, GAP.
- IDLE: if any req_i bit high at edge N, select winner; at edge N latch addr/data of winner into DDR_WRITE_ADDR/DATA, set DDR_WRITE_REQ=1, grant_id=winner, clear watchdog, go XFER. DDR_WRITE_REQ is visible in cycle after edge N (one-cycle request-to-DDR latency).
- Winner selection: PRIORITY_MODE=1 -> lowest index with req high. PRIORITY_MODE=0 -> first req high scanning grant_id+1, grant_id+2, ... modulo NUM_REQ. Bits of req_i at index >= NUM_REQ do not exist; grant_id never exceeds NUM_REQ-1.
- XFER: DDR_WRITE_ADDR/DATA/REQ held stable. On edge with DDR_WRITE_READY=1: DDR_WRITE_REQ<=0, ack_o[grant_id]<=1 (for exactly one cycle), go GAP. Else watchdog increments; on edge where watchdog==TIMEOUT_CYCLES-1 and READY=0: DDR_WRITE_REQ<=0, err_o[grant_id]<=1 for one cycle, go GAP. READY and timeout on the same edge -> READY wins (ack, no err).
- Dropping req_i of the granted requester during XFER does not cancel the transfer; word completes and ack is still pulsed.
- GAP: exactly one cycle; ack_o/err_o return to 0; no new grant (gives requester the ack cycle to drop req). Go IDLE. Minimum spacing between DDR_WRITE_REQ pulses is therefore 3 cycles when READY returns immediately.
- Requester contract: keep req_i high until ack_o or err_o pulse seen; drop it on the edge after the pulse or present next word immediately (the next word is eligible after GAP).
- DDR_WRITE_READY while in IDLE/GAP is ignored.
- Watchdog width 16 bits; saturates, never wraps.
- At most one bit of ack_o|err_o is high in any cycle.

Test Plan:
- Single write: req_i=3'b001, addr0=0x0900_0001, data0=0xC012_3456, READY asserted 2 cycles after DDR_WRITE_REQ -> DDR port shows those values, REQ high 3 cycles, ack_o=3'b001 for 1 cycle, grant_id=0.
- Round-robin: req_i=3'b111 held, READY tied high -> grant order 0,1,2,0,1,2; DDR_WRITE_REQ pulses every 3 cycles; each ack on matching bit.
- Fixed priority (PRIORITY_MODE=1): req_i=3'b110 then bit0 raised during XFER of 1 -> next grant is 0 before 2.
- Timeout (TIMEOUT_CYCLES=8): req_i=3'b100, READY held low -> DDR_WRITE_REQ drops after 8 cycles in XFER, err_o=3'b100 one cycle, ack_o stays 0; READY pulsed later in IDLE has no effect.
- READY and timeout coincident on final watchdog cycle -> ack_o pulses, err_o stays 0.
- Async reset mid-XFER: drop sys_rst_n with DDR_WRITE_REQ=1 -> DDR_WRITE_REQ, busy, ack_o, err_o go 0 immediately without a clock edge; after release first grant goes to index 0.
